// File: rtl/vga_vsync_gen_if.sv
// vga_vsync_gen_if: line-pulse input and vertical timing outputs of the vertical sync stage
//   ENABLE      run enable, low holds the stage idle
//   LINE_DONE   one pulse per completed horizontal line
//   VGA_VS      vertical sync, active low
//   V_ACTIVE    high during the active rows
//   LINE_NUM    active row index, 0 outside the active rows
//   FRAME_START one-cycle pulse on the front porch to sync wrap
interface vga_vsync_gen_if #(parameter int LINE_W = 10);
  logic              ENABLE;
  logic              LINE_DONE;
  logic              VGA_VS;
  logic              V_ACTIVE;
  logic [LINE_W-1:0] LINE_NUM;
  logic              FRAME_START;
  modport master (output ENABLE, LINE_DONE, input VGA_VS, V_ACTIVE, LINE_NUM, FRAME_START);
  modport slave  (input ENABLE, LINE_DONE, output VGA_VS, V_ACTIVE, LINE_NUM, FRAME_START);
endinterface

// File: rtl/vga_vsync_gen.sv
// vga_vsync_gen: counts LINE_DONE pulses through sync, back porch, active and front porch
//   VGA_CLOCK  pixel clock, rising edge
//   RESET_N    asynchronous active-low reset
//   vif        slave side of vga_vsync_gen_if (ENABLE/LINE_DONE in, registered timing out)
module vga_vsync_gen #(
  parameter int VS_LINES   = 2,
  parameter int VBP_LINES  = 33,
  parameter int VACT_LINES = 480,
  parameter int VFP_LINES  = 10,
  parameter int LINE_W     = 10
) (
  input  logic             VGA_CLOCK,
  input  logic             RESET_N,
  vga_vsync_gen_if.slave   vif
);
  typedef enum logic [1:0] {SYNC, BACK_PORCH, ACTIVE, FRONT_PORCH} state_t;
  localparam logic [LINE_W-1:0] VS_LAST   = LINE_W'(VS_LINES - 1);
  localparam logic [LINE_W-1:0] VBP_LAST  = LINE_W'(VBP_LINES - 1);
  localparam logic [LINE_W-1:0] VACT_LAST = LINE_W'(VACT_LINES - 1);
  localparam logic [LINE_W-1:0] VFP_LAST  = LINE_W'(VFP_LINES - 1);
  state_t            state_q, state_d, next_state;
  logic [LINE_W-1:0] cnt_q, cnt_d, line_q, line_d, last;
  logic              vs_q, vs_d, act_q, act_d, fs_q, fs_d, wrap;
  always_comb begin
    last       = state_q == SYNC ? VS_LAST : state_q == BACK_PORCH ? VBP_LAST :
                 state_q == ACTIVE ? VACT_LAST : VFP_LAST;
    next_state = state_q == SYNC ? BACK_PORCH : state_q == BACK_PORCH ? ACTIVE :
                 state_q == ACTIVE ? FRONT_PORCH : SYNC;
    wrap       = vif.ENABLE && vif.LINE_DONE && cnt_q == last;
    state_d    = state_q;
    cnt_d      = cnt_q;
    if (!vif.ENABLE) begin
      state_d = SYNC;
      cnt_d   = '0;
    end else if (vif.LINE_DONE) begin
      state_d = wrap ? next_state : state_q;
      cnt_d   = wrap ? '0 : cnt_q + 1'b1;
    end
    // Outputs are decoded from the next state so they register on the same edge as the move.
    vs_d   = state_d != SYNC;
    act_d  = state_d == ACTIVE;
    line_d = act_d ? cnt_d : '0;
    fs_d   = wrap && state_q == FRONT_PORCH;
  end
  always_ff @(posedge VGA_CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= SYNC;
      cnt_q   <= '0;
      vs_q    <= 1'b0;
      act_q   <= 1'b0;
      line_q  <= '0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vs_q    <= vs_d;
      act_q   <= act_d;
      line_q  <= line_d;
      fs_q    <= fs_d;
    end
  end
  assign vif.VGA_VS      = vs_q;
  assign vif.V_ACTIVE    = act_q;
  assign vif.LINE_NUM    = line_q;
  assign vif.FRAME_START = fs_q;
endmodule

// File: tb/tb_vga_vsync_gen.sv
// tb_vga_vsync_gen: directed and randomized checks of vga_vsync_gen against a frame-position model
module tb_vga_vsync_gen;
  localparam int VS = 2, VBP = 3, VACT = 4, VFP = 1, LW = 10;
  localparam int TOT = VS + VBP + VACT + VFP;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0, errors = 0, fs_cnt = 0;
  int   pos;
  bit   m_fs;
  vga_vsync_gen_if #(.LINE_W(LW)) bus ();
  vga_vsync_gen #(.VS_LINES(VS), .VBP_LINES(VBP), .VACT_LINES(VACT), .VFP_LINES(VFP), .LINE_W(LW))
    dut (.VGA_CLOCK(clk), .RESET_N(rst_n), .vif(bus));
  always #5 clk = ~clk;
  function automatic bit e_vs(int p);
    return p >= VS;
  endfunction
  function automatic bit e_act(int p);
    return p >= VS + VBP && p < VS + VBP + VACT;
  endfunction
  function automatic int e_line(int p);
    return e_act(p) ? p - VS - VBP : 0;
  endfunction
  // Model: position within the frame in pulses since the last clean start.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos  <= 0;
      m_fs <= 1'b0;
    end else if (!bus.ENABLE) begin
      pos  <= 0;
      m_fs <= 1'b0;
    end else if (bus.LINE_DONE) begin
      m_fs <= pos == TOT - 1;
      pos  <= (pos + 1) % TOT;
    end else begin
      m_fs <= 1'b0;
    end
  end
  always @(negedge clk) begin
    checks++;
    if (bus.VGA_VS !== e_vs(pos) || bus.V_ACTIVE !== e_act(pos) ||
        bus.LINE_NUM !== LW'(e_line(pos)) || bus.FRAME_START !== m_fs) begin
      errors++;
      $display("FAIL model t=%0t vs/act/line/fs got %b/%b/%0d/%b want %b/%b/%0d/%b", $time,
               bus.VGA_VS, bus.V_ACTIVE, bus.LINE_NUM, bus.FRAME_START,
               e_vs(pos), e_act(pos), e_line(pos), m_fs);
    end
    if (bus.FRAME_START === 1'b1) fs_cnt++;
  end
  task automatic chk(string name, int got, int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask
  task automatic step();
    bus.LINE_DONE = 1'b1;
    @(negedge clk);
    bus.LINE_DONE = 1'b0;
    #1;
  endtask
  task automatic gap();
    repeat (7) @(negedge clk);
  endtask
  initial begin
    rst_n = 1'b0;
    bus.ENABLE = 1'b0;
    bus.LINE_DONE = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_vs", int'(bus.VGA_VS), 0);
    chk("reset_line", int'(bus.LINE_NUM), 0);
    rst_n = 1'b1;
    bus.ENABLE = 1'b1;
    fs_cnt = 0;
    gap();
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k % 10 == 1) chk("vs_after_p1", int'(bus.VGA_VS), 0);
      if (k % 10 == 2) chk("vs_after_p2", int'(bus.VGA_VS), 1);
      if (k % 10 == 5) chk("line_p5", int'(bus.LINE_NUM), 0);
      if (k % 10 == 8) chk("line_p8", int'(bus.LINE_NUM), 3);
      if (k % 10 == 9) chk("act_p9", int'(bus.V_ACTIVE), 0);
      if (k % 10 == 0) chk("fs_p10", int'(bus.FRAME_START), 1);
      gap();
    end
    chk("fs_count", fs_cnt, 2);
    for (int k = 0; k < 6; k++) begin
      step();
      gap();
    end
    chk("pre_reset_act", int'(bus.V_ACTIVE), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_act", int'(bus.V_ACTIVE), 0);
    chk("async_reset_line", int'(bus.LINE_NUM), 0);
    chk("async_reset_vs", int'(bus.VGA_VS), 0);
    @(negedge clk);
    rst_n = 1'b1;
    gap();
    for (int k = 0; k < 7; k++) begin
      step();
      if (k < 6) gap();
    end
    chk("line_before_drop", int'(bus.LINE_NUM), 2);
    @(negedge clk);
    bus.ENABLE = 1'b0;
    @(negedge clk);
    #1;
    chk("drop_act", int'(bus.V_ACTIVE), 0);
    chk("drop_line", int'(bus.LINE_NUM), 0);
    bus.LINE_DONE = 1'b1;
    @(negedge clk);
    bus.LINE_DONE = 1'b0;
    #1;
    chk("ignored_vs", int'(bus.VGA_VS), 0);
    @(negedge clk);
    bus.ENABLE = 1'b1;
    gap();
    step();
    chk("restart_p1_vs", int'(bus.VGA_VS), 0);
    gap();
    step();
    chk("restart_p2_vs", int'(bus.VGA_VS), 1);
    gap();
    for (int k = 0; k < 8; k++) begin
      step();
      gap();
    end
    bus.LINE_DONE = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 10) bus.LINE_DONE = 1'b0;
      #1;
      if (c >= 5 && c <= 8) chk("dense_line", int'(bus.LINE_NUM), c - 5);
      if (c == 10) chk("dense_fs", int'(bus.FRAME_START), 1);
    end
    repeat (3000) begin
      @(negedge clk);
      bus.ENABLE = $urandom_range(0, 49) != 0;
      bus.LINE_DONE = $urandom_range(0, 2) == 0;
    end
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
